aska_npg_multi: RTL and testbench
=================================

Name: aska_npg_multi

Overview:
Parametrised successor of the single-phase ASKA neural pulse generator. It produces periodic stimulation pulses, either monophasic or biphasic with an interphase gap. Pulse amplitude ramps up and down in configurable steps. Outputs drive the stimulator DAC front end (stim_p / stim_n / amp) and report overruns.

Parameters:
FREQ_W, 12, width of period counter and freq input
PHASE_W, 4, width of phase-duration and gap counters
AMP_W, 8, width of amplitude, target and step values
RDIV_W, 6, width of ramp divider (pulses per amplitude step)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
enable  in  1  run request; falling edge starts ramp-down
mode  in  1  0 = biphasic, 1 = monophasic (PH2 skipped)
freq  in  FREQ_W  period = freq+1 cycles
phase  in  PHASE_W  each phase lasts phase+1 cycles
gap  in  PHASE_W  interphase gap in cycles (0 = none)
target  in  AMP_W  amplitude setpoint
up  in  AMP_W  ramp-up step
down  in  AMP_W  ramp-down step
ramp_div  in  RDIV_W  amplitude step applied every ramp_div+1 launches while enabled
clr_ovr  in  1  clears overrun flag
stim_p  out  1  high during cathodic phase PH1
stim_n  out  1  high during anodic phase PH2
amp  out  AMP_W  current pulse amplitude
launch  out  1  one-cycle strobe on PH1 entry
active  out  1  generator running (run flag)
overrun  out  1  sticky: tick arrived while FSM not IDLE

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Reset clears all state. Outputs after reset: stim_p=0, stim_n=0, amp=0, launch=0, active=0, overrun=0; FSM=IDLE; pcnt=0; rdiv=0.
- run/active: set on the edge where enable=1 is sampled and run=0; pcnt=0 on that edge. Cleared only by reset or by ramp-down termination.
- Period counter pcnt: while run=1, pcnt increments each cycle. tick = run & (pcnt >= freq), combinational. On tick, pcnt returns to 0. Using >= prevents runaway if freq is lowered mid-count. First launch occurs freq+1 cycles after run is set; steady period is freq+1 cycles.
- FSM states: IDLE, PH1, GAP, PH2.
  - IDLE→PH1 on tick. mode, phase and gap are latched at this edge; later changes take effect at the next launch.
  - PH1 lasts phase+1 cycles → GAP if gap≠0 and mode=0; → PH2 if gap=0 and mode=0; → IDLE if mode=1.
  - GAP lasts gap cycles → PH2.
  - PH2 lasts phase+1 cycles → IDLE.
- Outputs registered from state: stim_p = (state==PH1) & (amp≠0); stim_n = (state==PH2) & (amp≠0); launch=1 for exactly the first PH1 cycle.
- Overrun: tick while FSM≠IDLE is dropped and sets overrun, with no launch and pcnt wrapping normally. clr_ovr clears overrun; a simultaneous set wins.
- Amplitude update at each launch (same edge as IDLE→PH1), using unsigned saturating arithmetic at AMP_W bits:
  - enable=1: rdiv increments. When rdiv==ramp_div, rdiv→0 and a step is applied:
    - amp<target: amp=min(amp+up, target)
    - amp>target: amp=max(amp−down, target)
    - amp==target: amp unchanged
  - enable=0 (ramp-down): divider ignored, rdiv→0, amp=max(amp−down, 0). If down=0, amp is forced to 0.
  - If the new amp is 0 while enable=0: no pulse is emitted (FSM stays IDLE, launch=0), run→0, pcnt→0.
- Re-enable during ramp-down: ramping resumes toward target from the current amp; run stays 1; the period is not restarted.
- enable rising while run=0 (including after termination): fresh start with pcnt=0 and amp keeping its last value (0 after termination).
- Pulses with amp=0 while enabled (e.g. target=0): FSM timing runs, launch asserts, stim_p/stim_n stay 0.
- Reset mid-pulse: outputs drop to reset values on the same edge.

Test Plan:
1. Basic biphasic timing. Stimulus: freq=9, phase=2, gap=1, mode=0, target=8, up=8, ramp_div=0, enable at edge E. Required: launch at E+10, then every 10 cycles; stim_p high 3 cycles, 1 low cycle, stim_n high 3 cycles; amp=8 from the first pulse.
2. Ramp-up with divider. Stimulus: target=10, up=4, ramp_div=1. Required: amp over successive launches = 0,4,4,8,8,10,10 (saturates at target); stim stays low at the first launch (amp=0).
3. Ramp-down after disable. Stimulus: amp=10, down=3, enable→0. Required: amp at launches = 7,4,1, then no launch at the next tick, active→0 and pcnt=0. Repeat with down=0: active→0 at the next tick with no pulse.
4. Overrun. Stimulus: freq=3, phase=3, gap=2, mode=0. Required: ticks during PH1/GAP/PH2 are dropped and overrun=1 stays set; clr_ovr clears it; a simultaneous tick and clr_ovr leaves overrun=1.
5. Monophasic and live changes. Stimulus: mode=1, phase=0. Required: stim_p for 1 cycle and stim_n never asserts. Change phase mid-PH1: current pulse keeps the old width, next pulse uses the new one. Lower freq from 20 to 5 while pcnt=12: wrap on the next cycle.
6. Reset mid-pulse. Stimulus: assert reset during PH2 with amp=8. Required: all outputs 0 on that edge; after release with enable=1, first launch comes freq+1 cycles after restart.

Source files
------------

// File: rtl/aska_npg_multi.sv
// Multi-phase ASKA neural pulse generator: periodic mono/biphasic pulses
// with interphase gap, ramped amplitude and sticky overrun reporting.
module aska_npg_multi #(
  parameter int FREQ_W  = 12,
  parameter int PHASE_W = 4,
  parameter int AMP_W   = 8,
  parameter int RDIV_W  = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               mode,
  input  logic [FREQ_W-1:0]  freq,
  input  logic [PHASE_W-1:0] phase,
  input  logic [PHASE_W-1:0] gap,
  input  logic [AMP_W-1:0]   target,
  input  logic [AMP_W-1:0]   up,
  input  logic [AMP_W-1:0]   down,
  input  logic [RDIV_W-1:0]  ramp_div,
  input  logic               clr_ovr,
  output logic               stim_p,
  output logic               stim_n,
  output logic [AMP_W-1:0]   amp,
  output logic               launch,
  output logic               active,
  output logic               overrun
);

  typedef enum logic [1:0] {IDLE, PH1, GAP, PH2} state_t;

  state_t             state_q, state_d;
  logic [FREQ_W-1:0]  pcnt_q, pcnt_d;
  logic               run_q, run_d;
  logic [AMP_W-1:0]   amp_q, amp_d;
  logic [RDIV_W-1:0]  rdiv_q, rdiv_d;
  logic               ovr_q, ovr_d;
  logic [PHASE_W-1:0] cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] gap_q, gap_d;
  logic               launch_q, launch_d;
  logic               stim_p_q, stim_p_d;
  logic               stim_n_q, stim_n_d;

  logic               tick;
  logic [AMP_W:0]     upSum;
  logic [AMP_W-1:0]   stepAmp;
  logic [AMP_W-1:0]   rampDownAmp;

  // Saturating amplitude candidates: one ramp step toward target, and one ramp-down step toward zero
  always_comb begin
    upSum       = {1'b0, amp_q} + {1'b0, up};
    stepAmp     = amp_q;
    rampDownAmp = '0;
    if (amp_q < target) begin
      stepAmp = (upSum >= {1'b0, target}) ? target : upSum[AMP_W-1:0];
    end else if (amp_q > target) begin
      stepAmp = ((amp_q - target) <= down) ? target : (amp_q - down);
    end
    if ((down != '0) && (amp_q > down)) begin
      rampDownAmp = amp_q - down;
    end
  end

  assign tick = run_q && (pcnt_q >= freq);

  // Next-state logic: period counter, run flag, overrun, pulse FSM and amplitude update at launch
  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    run_d    = run_q;
    amp_d    = amp_q;
    rdiv_d   = rdiv_q;
    ovr_d    = ovr_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    phase_d  = phase_q;
    gap_d    = gap_q;
    launch_d = 1'b0;

    if (run_q) begin
      pcnt_d = tick ? '0 : (pcnt_q + FREQ_W'(1));
    end
    if (enable && !run_q) begin
      run_d  = 1'b1;
      pcnt_d = '0;
    end

    if (clr_ovr) begin
      ovr_d = 1'b0;
    end
    if (tick && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (tick) begin
          if (enable) begin
            if (rdiv_q == ramp_div) begin
              rdiv_d = '0;
              amp_d  = stepAmp;
            end else begin
              rdiv_d = rdiv_q + RDIV_W'(1);
            end
          end else begin
            rdiv_d = '0;
            amp_d  = rampDownAmp;
          end
          if (!enable && (rampDownAmp == '0)) begin
            run_d  = 1'b0;
            pcnt_d = '0;
          end else begin
            state_d  = PH1;
            cnt_d    = '0;
            mode_d   = mode;
            phase_d  = phase;
            gap_d    = gap;
            launch_d = 1'b1;
          end
        end
      end
      PH1: begin
        if (cnt_q == phase_q) begin
          cnt_d = '0;
          if (mode_q) begin
            state_d = IDLE;
          end else if (gap_q != '0) begin
            state_d = GAP;
          end else begin
            state_d = PH2;
          end
        end else begin
          cnt_d = cnt_q + PHASE_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == (gap_q - PHASE_W'(1))) begin
          cnt_d   = '0;
          state_d = PH2;
        end else begin
          cnt_d = cnt_q + PHASE_W'(1);
        end
      end
      PH2: begin
        if (cnt_q == phase_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + PHASE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    stim_p_d = (state_d == PH1) && (amp_d != '0);
    stim_n_d = (state_d == PH2) && (amp_d != '0);
  end

  // State register with synchronous reset; outputs are registered alongside the FSM state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pcnt_q   <= '0;
      run_q    <= 1'b0;
      amp_q    <= '0;
      rdiv_q   <= '0;
      ovr_q    <= 1'b0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      phase_q  <= '0;
      gap_q    <= '0;
      launch_q <= 1'b0;
      stim_p_q <= 1'b0;
      stim_n_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      run_q    <= run_d;
      amp_q    <= amp_d;
      rdiv_q   <= rdiv_d;
      ovr_q    <= ovr_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      phase_q  <= phase_d;
      gap_q    <= gap_d;
      launch_q <= launch_d;
      stim_p_q <= stim_p_d;
      stim_n_q <= stim_n_d;
    end
  end

  assign stim_p  = stim_p_q;
  assign stim_n  = stim_n_q;
  assign amp     = amp_q;
  assign launch  = launch_q;
  assign active  = run_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_aska_npg_multi.sv
// Directed self-checking bench for the multi-phase pulse generator.
module tb_aska_npg_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        mode;
  logic [11:0] freq;
  logic [3:0]  phase;
  logic [3:0]  gap;
  logic [7:0]  target;
  logic [7:0]  up;
  logic [7:0]  down;
  logic [5:0]  ramp_div;
  logic        clr_ovr;
  logic        stim_p;
  logic        stim_n;
  logic [7:0]  amp;
  logic        launch;
  logic        active;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  aska_npg_multi dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .mode     (mode),
    .freq     (freq),
    .phase    (phase),
    .gap      (gap),
    .target   (target),
    .up       (up),
    .down     (down),
    .ramp_div (ramp_div),
    .clr_ovr  (clr_ovr),
    .stim_p   (stim_p),
    .stim_n   (stim_n),
    .amp      (amp),
    .launch   (launch),
    .active   (active),
    .overrun  (overrun)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 unit past the last one
  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [11:0] f, input logic [3:0] ph, input logic [3:0] g,
                               input logic m, input logic [7:0] t, input logic [7:0] u,
                               input logic [7:0] d, input logic [5:0] rd);
    freq     = f;
    phase    = ph;
    gap      = g;
    mode     = m;
    target   = t;
    up       = u;
    down     = d;
    ramp_div = rd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Hard time bound so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rampExp [7];
    rampExp = '{8'd0, 8'd4, 8'd4, 8'd8, 8'd8, 8'd10, 8'd10};

    reset   = 1'b1;
    enable  = 1'b0;
    clr_ovr = 1'b0;
    applyStimulus(12'd9, 4'd2, 4'd1, 1'b0, 8'd8, 8'd8, 8'd0, 6'd0);
    stepCycles(2);

    // Reset state
    checkOutput("rst_stim_p", stim_p, 0);
    checkOutput("rst_stim_n", stim_n, 0);
    checkOutput("rst_amp", amp, 0);
    checkOutput("rst_launch", launch, 0);
    checkOutput("rst_active", active, 0);
    checkOutput("rst_overrun", overrun, 0);

    // 1: basic biphasic timing
    reset  = 1'b0;
    enable = 1'b1;
    stepCycles(1);
    checkOutput("t1_active", active, 1);
    stepCycles(9);
    checkOutput("t1_no_early_launch", launch, 0);
    stepCycles(1);
    checkOutput("t1_launch", launch, 1);
    checkOutput("t1_stim_p", stim_p, 1);
    checkOutput("t1_amp", amp, 8);
    stepCycles(1);
    checkOutput("t1_launch_strobe", launch, 0);
    checkOutput("t1_stim_p_hold", stim_p, 1);
    stepCycles(2);
    checkOutput("t1_gap_p", stim_p, 0);
    checkOutput("t1_gap_n", stim_n, 0);
    stepCycles(1);
    checkOutput("t1_stim_n", stim_n, 1);
    stepCycles(2);
    checkOutput("t1_stim_n_hold", stim_n, 1);
    stepCycles(1);
    checkOutput("t1_stim_n_end", stim_n, 0);
    stepCycles(3);
    checkOutput("t1_period", launch, 1);

    // 2: ramp-up with divider
    reset = 1'b1;
    stepCycles(1);
    reset = 1'b0;
    applyStimulus(12'd9, 4'd0, 4'd0, 1'b1, 8'd10, 8'd4, 8'd3, 6'd1);
    stepCycles(1);
    for (int i = 0; i < 7; i++) begin
      stepCycles(10);
      checkOutput($sformatf("t2_launch%0d", i), launch, 1);
      checkOutput($sformatf("t2_amp%0d", i), amp, rampExp[i]);
      if (i == 0) checkOutput("t2_stim_zero_amp", stim_p, 0);
      if (i == 1) checkOutput("t2_stim_amp4", stim_p, 1);
    end

    // 3: ramp-down after disable, amp starts at 10
    enable = 1'b0;
    stepCycles(10);
    checkOutput("t3_amp7", amp, 7);
    checkOutput("t3_launch7", launch, 1);
    stepCycles(10);
    checkOutput("t3_amp4", amp, 4);
    stepCycles(10);
    checkOutput("t3_amp1", amp, 1);
    checkOutput("t3_active_still", active, 1);
    stepCycles(10);
    checkOutput("t3_no_launch", launch, 0);
    checkOutput("t3_active_off", active, 0);
    checkOutput("t3_amp0", amp, 0);
    enable = 1'b1;
    stepCycles(1);
    checkOutput("t3_restart_active", active, 1);
    stepCycles(10);
    checkOutput("t3_restart_launch", launch, 1);
    checkOutput("t3_restart_amp", amp, 0);
    stepCycles(10);
    checkOutput("t3_restart_amp4", amp, 4);
    down   = 8'd0;
    enable = 1'b0;
    stepCycles(10);
    checkOutput("t3_down0_no_launch", launch, 0);
    checkOutput("t3_down0_active", active, 0);
    checkOutput("t3_down0_amp", amp, 0);

    // 4: overrun
    reset = 1'b1;
    stepCycles(1);
    reset = 1'b0;
    applyStimulus(12'd3, 4'd3, 4'd2, 1'b0, 8'd8, 8'd8, 8'd3, 6'd0);
    enable = 1'b1;
    stepCycles(1);
    stepCycles(4);
    checkOutput("t4_launch", launch, 1);
    checkOutput("t4_amp", amp, 8);
    stepCycles(3);
    checkOutput("t4_ovr_before", overrun, 0);
    stepCycles(1);
    checkOutput("t4_ovr_set", overrun, 1);
    checkOutput("t4_gap_p", stim_p, 0);
    stepCycles(4);
    checkOutput("t4_dropped", launch, 0);
    checkOutput("t4_ovr_sticky", overrun, 1);
    checkOutput("t4_ph2", stim_n, 1);
    stepCycles(4);
    checkOutput("t4_next_launch", launch, 1);
    clr_ovr = 1'b1;
    stepCycles(1);
    checkOutput("t4_clr", overrun, 0);
    clr_ovr = 1'b0;
    stepCycles(2);
    checkOutput("t4_clr_hold", overrun, 0);
    clr_ovr = 1'b1;
    stepCycles(1);
    checkOutput("t4_set_wins", overrun, 1);
    clr_ovr = 1'b0;

    // 5: monophasic, live phase and freq changes
    reset = 1'b1;
    stepCycles(1);
    reset = 1'b0;
    applyStimulus(12'd9, 4'd0, 4'd0, 1'b1, 8'd8, 8'd8, 8'd3, 6'd0);
    stepCycles(1);
    stepCycles(10);
    checkOutput("t5_launch", launch, 1);
    checkOutput("t5_stim_p", stim_p, 1);
    checkOutput("t5_stim_n", stim_n, 0);
    stepCycles(1);
    checkOutput("t5_stim_p_1cyc", stim_p, 0);
    checkOutput("t5_stim_n_never", stim_n, 0);
    phase = 4'd3;
    stepCycles(9);
    checkOutput("t5_wide_start", stim_p, 1);
    phase = 4'd0;
    stepCycles(3);
    checkOutput("t5_old_width", stim_p, 1);
    checkOutput("t5_mono_n", stim_n, 0);
    stepCycles(1);
    checkOutput("t5_old_width_end", stim_p, 0);
    stepCycles(6);
    checkOutput("t5_new_launch", stim_p, 1);
    freq = 12'd20;
    stepCycles(1);
    checkOutput("t5_new_width", stim_p, 0);
    stepCycles(11);
    checkOutput("t5_freq20_pending", launch, 0);
    freq = 12'd5;
    stepCycles(1);
    checkOutput("t5_freq_wrap", launch, 1);
    stepCycles(5);
    checkOutput("t5_freq5_wait", launch, 0);
    stepCycles(1);
    checkOutput("t5_freq5_period", launch, 1);

    // 6: reset mid-pulse
    applyStimulus(12'd9, 4'd2, 4'd1, 1'b0, 8'd8, 8'd8, 8'd3, 6'd0);
    stepCycles(10);
    checkOutput("t6_launch", launch, 1);
    stepCycles(4);
    checkOutput("t6_ph2", stim_n, 1);
    checkOutput("t6_amp", amp, 8);
    reset = 1'b1;
    stepCycles(1);
    checkOutput("t6_rst_stim_p", stim_p, 0);
    checkOutput("t6_rst_stim_n", stim_n, 0);
    checkOutput("t6_rst_amp", amp, 0);
    checkOutput("t6_rst_launch", launch, 0);
    checkOutput("t6_rst_active", active, 0);
    checkOutput("t6_rst_overrun", overrun, 0);
    reset = 1'b0;
    stepCycles(1);
    checkOutput("t6_restart_active", active, 1);
    stepCycles(9);
    checkOutput("t6_restart_wait", launch, 0);
    stepCycles(1);
    checkOutput("t6_restart_launch", launch, 1);
    checkOutput("t6_restart_amp", amp, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
